// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: FSM state encoding,
// next-PC select encoding, default vectors and the branch sign-extension helper.
package fetch_pkg;

   localparam int PC_W        = 32;
   localparam int BR_W        = 16;
   localparam int DRAIN_CNT_W = 4;

   localparam logic [PC_W-1:0] DEF_RESET_VECTOR = 32'd50;
   localparam logic [PC_W-1:0] DEF_INT_VECTOR   = 32'd0;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_VECTOR = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      PC_SEL_RESET  = 3'd0,
      PC_SEL_BRANCH = 3'd1,
      PC_SEL_EPC    = 3'd2,
      PC_SEL_INT    = 3'd3,
      PC_SEL_HOLD   = 3'd4,
      PC_SEL_INC    = 3'd5
   } pc_sel_e;

   // Branch targets arrive as 16-bit values and are sign-extended to a full PC.
   function automatic logic [PC_W-1:0] sext_branch(input logic [BR_W-1:0] addr);
      return {{(PC_W-BR_W){addr[BR_W-1]}}, addr};
   endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selector: reset vector, branch target (sign-extended),
// saved EPC, interrupt vector, hold, or PC+1 (wraps modulo 2^32).
module pc_next_mux
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
   parameter logic [PC_W-1:0] INT_VECTOR   = DEF_INT_VECTOR
) (
   input  pc_sel_e          sel,
   input  logic [PC_W-1:0]  pc_cur,
   input  logic [PC_W-1:0]  epc_cur,
   input  logic [BR_W-1:0]  branch_addr,
   output logic [PC_W-1:0]  pc_next
);

   // Pick the next fetch address from the source chosen by the sequencer.
   always_comb begin
      // NOTE: pc_next gets a default before the case so no latch is inferred.
      pc_next = pc_cur;
      case (sel)
         PC_SEL_RESET:  pc_next = RESET_VECTOR;
         PC_SEL_BRANCH: pc_next = sext_branch(branch_addr);
         PC_SEL_EPC:    pc_next = epc_cur;
         PC_SEL_INT:    pc_next = INT_VECTOR;
         PC_SEL_HOLD:   pc_next = pc_cur;
         PC_SEL_INC:    pc_next = pc_cur + 32'd1;
         default:       pc_next = pc_cur;
      endcase
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC sequencer with a RUN/DRAIN/VECTOR interrupt-entry FSM.
// Owns the PC and EPC registers; all state updates on the falling clock edge
// so the instruction memory can read on the rising edge.
// Optional macro EPC_RETURN_EN adds the rti input (return to EPC from RUN).
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
   parameter logic [31:0] INT_VECTOR   = DEF_INT_VECTOR,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch,
   input  logic [15:0] branch_addr,
   input  logic        int_req,
`ifdef EPC_RETURN_EN
   input  logic        rti,
`endif
   output logic [31:0] pc,
   output logic        fetch_valid,
   output logic        flush_fd,
   output logic        int_ack,
   output logic [31:0] epc,
   output logic        busy
);

   // Drain counter counts down to zero; loading N-1 gives N DRAIN cycles.
   localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

   state_e                 state_q, state_d;
   logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
   logic [PC_W-1:0]        pc_q, pc_d;
   logic [PC_W-1:0]        epc_q, epc_d;
   logic                   fetch_valid_q, fetch_valid_d;
   logic                   flush_fd_q, flush_fd_d;
   logic                   int_ack_q, int_ack_d;
   pc_sel_e                pc_sel;
   logic                   rti_req;
   logic                   drain_done;

`ifdef EPC_RETURN_EN
   assign rti_req = rti;
`else
   assign rti_req = 1'b0;
`endif

   // Drain finishes on the cycle the counter is at zero and no stall holds it.
   assign drain_done = (drain_cnt_q == '0) && !stall;

   // State register; synchronous reset is folded into state_d.
   always_ff @(negedge clk) begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values.
      state_q <= state_d;
   end

   // Next-state logic: RUN enters DRAIN only when no branch/rti outranks int_req.
   always_comb begin
      state_d = state_q;
      if (reset) begin
         state_d = ST_RUN;
      end else begin
         case (state_q)
            ST_RUN:    if (!branch && !rti_req && int_req) state_d = ST_DRAIN;
            ST_DRAIN:  if (drain_done) state_d = ST_VECTOR;
            ST_VECTOR: state_d = ST_RUN;
            default:   state_d = ST_RUN;
         endcase
      end
   end

   // Output/datapath logic: next PC source, EPC capture, drain count, pulses.
   // The interrupt vector is loaded on the edge leaving DRAIN and held through
   // the VECTOR cycle, so pc shows INT_VECTOR DRAIN_CYCLES+1 edges after entry.
   always_comb begin
      pc_sel        = PC_SEL_HOLD;
      epc_d         = epc_q;
      drain_cnt_d   = drain_cnt_q;
      fetch_valid_d = fetch_valid_q;
      flush_fd_d    = 1'b0;
      int_ack_d     = 1'b0;
      if (reset) begin
         pc_sel        = PC_SEL_RESET;
         epc_d         = '0;
         drain_cnt_d   = '0;
         fetch_valid_d = 1'b1;
      end else begin
         case (state_q)
            ST_RUN: begin
               fetch_valid_d = 1'b1;
               if (branch) begin
                  pc_sel     = PC_SEL_BRANCH;
                  flush_fd_d = 1'b1;
               end else if (rti_req) begin
                  pc_sel     = PC_SEL_EPC;
                  flush_fd_d = 1'b1;
               end else if (int_req) begin
                  epc_d         = pc_q;
                  drain_cnt_d   = DRAIN_LOAD;
                  fetch_valid_d = 1'b0;
                  flush_fd_d    = 1'b1;
               end else if (stall) begin
                  pc_sel = PC_SEL_HOLD;
               end else begin
                  pc_sel = PC_SEL_INC;
               end
            end
            ST_DRAIN: begin
               fetch_valid_d = 1'b0;
               // A branch resolving during drain becomes the return address.
               if (branch) epc_d = sext_branch(branch_addr);
               if (drain_done) begin
                  pc_sel        = PC_SEL_INT;
                  int_ack_d     = 1'b1;
                  fetch_valid_d = 1'b1;
               end else if (!stall) begin
                  drain_cnt_d = drain_cnt_q - 1'b1;
               end
            end
            ST_VECTOR: begin
               pc_sel        = PC_SEL_INT;
               fetch_valid_d = 1'b1;
            end
            default: begin
               pc_sel = PC_SEL_HOLD;
            end
         endcase
      end
   end

   pc_next_mux #(
      .RESET_VECTOR (RESET_VECTOR),
      .INT_VECTOR   (INT_VECTOR)
   ) u_pc_next_mux (
      .sel         (pc_sel),
      .pc_cur      (pc_q),
      .epc_cur     (epc_q),
      .branch_addr (branch_addr),
      .pc_next     (pc_d)
   );

   // Datapath and output registers.
   always_ff @(negedge clk) begin
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      drain_cnt_q   <= drain_cnt_d;
      fetch_valid_q <= fetch_valid_d;
      flush_fd_q    <= flush_fd_d;
      int_ack_q     <= int_ack_d;
   end

   assign pc          = pc_q;
   assign epc         = epc_q;
   assign fetch_valid = fetch_valid_q;
   assign flush_fd    = flush_fd_q;
   assign int_ack     = int_ack_q;
   assign busy        = (state_q != ST_RUN);

endmodule
